act_quantizer: RTL and testbench
================================

Name: act_quantizer

Overview:
- Re-quantizes post-ReLU dequantized activations (unsigned Q16.16) back to uint8 for the next layer's input buffer.
- Per element: multiply by an inverse scale, round half-up, saturate to 0..255.
- Packs four bytes per 32-bit word and delivers words over a valid/ready stream.
- Sits between the dequantizer output and the activation write-back path.

Parameters:
- IN_W, 32, input activation width, unsigned Q16.16.
- SCALE_W, 32, inverse-scale width, unsigned Q16.16.
- FRAC_SHIFT, 32, product right-shift: sum of input and scale fraction bits.
- LANES, 4, bytes packed per output word.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  input element valid.
- o_ready  out  1  block accepts input this cycle.
- i_data  in  IN_W  dequantized activation, unsigned Q16.16.
- i_inv_s  in  SCALE_W  inverse scale 1/s, Q16.16; sampled with each element.
- i_last  in  1  marks final element of a tile; forces flush of a partial word.
- o_valid  out  1  packed word valid.
- i_ready  in  1  downstream accepts word.
- o_data  out  8*LANES  packed uint8; lane 0 in bits [7:0].
- o_keep  out  LANES  per-lane byte valid.
- o_last  out  1  word carries the tile's last element.

Behaviour:
- Reset: all outputs 0, lane counter 0, pipeline valids 0. A reset mid-tile discards partial words and in-flight elements.
- Handshakes:
  - Input transfer when i_valid && o_ready; output transfer when o_valid && i_ready.
  - Global advance en = !o_valid || i_ready; o_ready = en. The pipeline freezes entirely while en = 0.
  - o_data, o_keep and o_last hold stable while o_valid && !i_ready.
- Stage 1 (S1): register the product i_data*i_inv_s (IN_W+SCALE_W bits) and i_last.
- Stage 2 (S2):
  - q = (prod + 2^(FRAC_SHIFT-1)) >> FRAC_SHIFT.
  - If q > 255, q = 255 (flag sat). Zero scale gives 0.
- Stage 3 (S3), packer with lane counter lane in 0..LANES-1:
  - Writes q to byte lane[lane] of an accumulation register and sets keep[lane].
  - If lane == LANES-1 or last: o_data/o_keep/o_last load, o_valid = 1, lane = 0, accumulator and keep cleared. Otherwise lane++.
  - A word completing while the previous one is still held is impossible, because en freezes S3.
- Latency: an element accepted at cycle t reaches S3 at the en-edge t+2. A word-completing element gives o_valid at t+3 with no stalls. Sustained throughput is 1 element/cycle, 1 word per LANES cycles.
- States: FILL (lane counting) and HOLD (o_valid high awaiting i_ready). HOLD→FILL on transfer. Back-to-back: a new word may load in the same cycle the old one transfers.
- i_last on lane LANES-1 produces a full keep with o_last = 1. A single-element tile gives keep = 4'b0001, upper bytes 0.
- A bubble (i_valid = 0) advances a pipeline stage with its valid = 0; the packer is unchanged.

Optional Feature:
- Macro QUANT_STATS_EN.
- When defined, adds output o_sat_count (16 bits):
  - Increments once per element saturated in S2, gated by en and the stage valid.
  - Sticks at 0xFFFF.
  - Cleared by i_reset and by the first element of a new tile (the element after an i_last).
- When undefined, the port and counter are absent. Data behaviour is identical in both builds.

Decomposition:
- Shared package holds: LANES, BYTE_W=8, UINT8_MAX=255, FRAC_SHIFT default, and the q_pack state enum {FILL, HOLD}.
- One natural sub-module: byte_packer (S3 lane counter, keep/last generation, output hold register). Multiply/round/saturate stays in the top.

Test Plan:
- inv_s=0x0001_0000; data 0x0005_8000 → q=6; data 0x0003_0000 with inv_s=0x0002_0000 → q=6; data 0x0000_7FFF → q=0.
- Elements 1,2,3,4 at inv_s=1.0, i_ready=1 → single word o_data=0x04030201, o_keep=4'b1111, o_last=0 at cycle t0+3.
- Elements 7,9 with i_last on 9 → o_data=0x00000907, o_keep=4'b0011, o_last=1; the next tile restarts at lane 0.
- data 0x0200_0000 (512.0) at inv_s=1.0 → byte 0xFF; with QUANT_STATS_EN, o_sat_count=1.
- Hold i_ready=0 for 5 cycles with a stream of 12 elements → o_ready drops, o_data stable, no loss or duplication; words 0x04030201, 0x08070605, 0x0C0B0A09 in order.
- Assert i_reset after 2 of 4 elements → all outputs 0 next cycle; the following 4 elements form a clean word.

Source files
------------

// File: rtl/act_quantizer_pkg.sv
// act_quantizer_pkg: shared constants and types for the activation re-quantizer.
//   LANES      - uint8 elements packed per output word
//   BYTE_W     - width of one packed element
//   UINT8_MAX  - saturation ceiling for a quantized element
//   FRAC_SHIFT - default product right-shift (input + scale fraction bits)
//   q_pack_e   - packer state: FILL (collecting lanes) / HOLD (word waiting)
package act_quantizer_pkg;

  localparam int unsigned LANES      = 4;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned UINT8_MAX  = 255;
  localparam int unsigned FRAC_SHIFT = 32;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } q_pack_e;

endpackage

// File: rtl/act_quantizer_if.sv
// act_quantizer_if: input element stream and packed output word stream.
//   Input  side: i_valid / o_ready, i_data (Q16.16), i_inv_s (Q16.16), i_last
//   Output side: o_valid / i_ready, o_data (LANES bytes), o_keep, o_last
//   o_sat_count exists only when QUANT_STATS_EN is defined.
// Modports: slave = the quantizer, master = the producer/consumer around it.
interface act_quantizer_if #(
  parameter int unsigned IN_W    = 32,
  parameter int unsigned SCALE_W = 32,
  parameter int unsigned LANES   = 4
) ();

  logic                 i_valid;
  logic                 o_ready;
  logic [IN_W-1:0]      i_data;
  logic [SCALE_W-1:0]   i_inv_s;
  logic                 i_last;
  logic                 o_valid;
  logic                 i_ready;
  logic [8*LANES-1:0]   o_data;
  logic [LANES-1:0]     o_keep;
  logic                 o_last;
`ifdef QUANT_STATS_EN
  logic [15:0]          o_sat_count;

  modport slave (
    input  i_valid, i_data, i_inv_s, i_last, i_ready,
    output o_ready, o_valid, o_data, o_keep, o_last, o_sat_count
  );

  modport master (
    output i_valid, i_data, i_inv_s, i_last, i_ready,
    input  o_ready, o_valid, o_data, o_keep, o_last, o_sat_count
  );
`else
  modport slave (
    input  i_valid, i_data, i_inv_s, i_last, i_ready,
    output o_ready, o_valid, o_data, o_keep, o_last
  );

  modport master (
    output i_valid, i_data, i_inv_s, i_last, i_ready,
    input  o_ready, o_valid, o_data, o_keep, o_last
  );
`endif

endinterface

// File: rtl/act_quantizer_byte_packer.sv
// act_quantizer_byte_packer: third pipeline stage. Collects quantized bytes into
// lanes, then moves the finished word into an output hold register.
//   clk_i, reset_i - clock, synchronous active-high reset
//   en_i           - global pipeline advance (freezes the packer when low)
//   valid_i        - a quantized byte is present this cycle
//   byte_i, last_i - the byte and its end-of-tile marker
//   ready_i        - downstream accepts the held word
//   valid_o, data_o, keep_o, last_o - held output word
module act_quantizer_byte_packer
  import act_quantizer_pkg::*;
#(
  parameter int unsigned LANES  = 4,
  parameter int unsigned BYTE_W = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    en_i,
  input  logic                    valid_i,
  input  logic [BYTE_W-1:0]       byte_i,
  input  logic                    last_i,
  input  logic                    ready_i,
  output logic                    valid_o,
  output logic [BYTE_W*LANES-1:0] data_o,
  output logic [LANES-1:0]        keep_o,
  output logic                    last_o
);

  localparam int unsigned LaneW = (LANES > 1) ? $clog2(LANES) : 1;

  q_pack_e                 state_q, state_d;
  logic [LaneW-1:0]        lane_q, lane_d;
  logic [BYTE_W*LANES-1:0] acc_q, acc_d, acc_merge;
  logic [LANES-1:0]        acc_keep_q, acc_keep_d, keep_merge;
  logic [BYTE_W*LANES-1:0] data_q, data_d;
  logic [LANES-1:0]        keep_q, keep_d;
  logic                    last_q, last_d;
  logic                    word_done;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= FILL;
      lane_q     <= '0;
      acc_q      <= '0;
      acc_keep_q <= '0;
      data_q     <= '0;
      keep_q     <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      acc_q      <= acc_d;
      acc_keep_q <= acc_keep_d;
      data_q     <= data_d;
      keep_q     <= keep_d;
      last_q     <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    acc_d      = acc_q;
    acc_keep_d = acc_keep_q;
    data_d     = data_q;
    keep_d     = keep_q;
    last_d     = last_q;

    // Accumulator and keep as they would look with the incoming byte merged in.
    acc_merge                             = acc_q;
    acc_merge[lane_q*BYTE_W +: BYTE_W]    = byte_i;
    keep_merge                            = acc_keep_q;
    keep_merge[lane_q]                    = 1'b1;
    word_done = (lane_q == LaneW'(LANES - 1)) || last_i;

    unique case (state_q)
      FILL:    state_d = FILL;
      HOLD:    if (ready_i) state_d = FILL;
      default: state_d = FILL;
    endcase

    // en_i is low only while a held word is refused, so a completing word can
    // never overwrite one that has not yet transferred; loading here while in
    // HOLD with ready_i high is the back-to-back case.
    if (en_i && valid_i) begin
      if (word_done) begin
        data_d     = acc_merge;
        keep_d     = keep_merge;
        last_d     = last_i;
        state_d    = HOLD;
        lane_d     = '0;
        acc_d      = '0;
        acc_keep_d = '0;
      end else begin
        lane_d     = lane_q + LaneW'(1);
        acc_d      = acc_merge;
        acc_keep_d = keep_merge;
      end
    end
  end

  assign valid_o = (state_q == HOLD);
  assign data_o  = data_q;
  assign keep_o  = keep_q;
  assign last_o  = last_q;

endmodule

// File: rtl/act_quantizer.sv
// act_quantizer: re-quantizes unsigned Q16.16 activations to uint8 and packs
// LANES bytes per output word.
//   S1: register i_data * i_inv_s and i_last
//   S2: round half-up, drop FRAC_SHIFT fraction bits, saturate to 0..255
//   S3: byte_packer lane fill and output hold register
// Ports:
//   i_clk   - clock, rising edge
//   i_reset - synchronous active-high reset; discards partial words
//   aq      - act_quantizer_if.slave carrying both element and word streams
// Optional: define QUANT_STATS_EN to add aq.o_sat_count, a per-tile count of
// saturated elements (sticky at 0xFFFF, cleared at the start of each tile).
module act_quantizer
  import act_quantizer_pkg::*;
#(
  parameter int unsigned IN_W       = 32,
  parameter int unsigned SCALE_W    = 32,
  parameter int unsigned FRAC_SHIFT = act_quantizer_pkg::FRAC_SHIFT,
  parameter int unsigned LANES      = act_quantizer_pkg::LANES
) (
  input logic            i_clk,
  input logic            i_reset,
  act_quantizer_if.slave aq
);

  localparam int unsigned ProdW = IN_W + SCALE_W;
  localparam int unsigned QW    = ProdW - FRAC_SHIFT;

  logic en;

  logic             s1_valid_q;
  logic [ProdW-1:0] s1_prod_q;
  logic             s1_last_q;

  logic [QW-1:0]     q_floor;
  logic [QW:0]       q_round;
  logic              q_sat;
  logic [BYTE_W-1:0] q_byte;

  logic              s2_valid_q;
  logic [BYTE_W-1:0] s2_byte_q;
  logic              s2_last_q;

  // The whole pipeline advances together; a refused held word freezes it.
  assign en         = !aq.o_valid || aq.i_ready;
  assign aq.o_ready = en;

  // S1: full-width product.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_valid_q <= 1'b0;
      s1_prod_q  <= '0;
      s1_last_q  <= 1'b0;
    end else if (en) begin
      s1_valid_q <= aq.i_valid;
      s1_prod_q  <= {{SCALE_W{1'b0}}, aq.i_data} * {{IN_W{1'b0}}, aq.i_inv_s};
      s1_last_q  <= aq.i_valid && aq.i_last;
    end
  end

  // Adding 2^(FRAC_SHIFT-1) then shifting equals the integer part plus the
  // first dropped fraction bit; one extra bit keeps the carry.
  assign q_floor = s1_prod_q[ProdW-1:FRAC_SHIFT];
  assign q_round = {1'b0, q_floor} + {{QW{1'b0}}, s1_prod_q[FRAC_SHIFT-1]};
  assign q_sat   = |q_round[QW:BYTE_W];
  // UINT8_MAX is the all-ones byte.
  assign q_byte  = q_sat ? {BYTE_W{1'b1}} : q_round[BYTE_W-1:0];

  // Lower fraction bits only influence rounding through the half bit.
  logic unused_frac;
  assign unused_frac = ^s1_prod_q[FRAC_SHIFT-2:0];

  // S2: quantized byte.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s2_valid_q <= 1'b0;
      s2_byte_q  <= '0;
      s2_last_q  <= 1'b0;
    end else if (en) begin
      s2_valid_q <= s1_valid_q;
      s2_byte_q  <= q_byte;
      s2_last_q  <= s1_last_q;
    end
  end

`ifdef QUANT_STATS_EN
  logic [15:0] sat_count_q;
  logic        new_tile_q;

  // new_tile_q marks that the next element to leave S1 opens a tile, which
  // restarts the count instead of adding to it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sat_count_q <= '0;
      new_tile_q  <= 1'b1;
    end else if (en && s1_valid_q) begin
      new_tile_q <= s1_last_q;
      if (new_tile_q) begin
        sat_count_q <= {15'd0, q_sat};
      end else if (q_sat && (sat_count_q != 16'hFFFF)) begin
        sat_count_q <= sat_count_q + 16'd1;
      end
    end
  end

  assign aq.o_sat_count = sat_count_q;
`endif

  // S3
  act_quantizer_byte_packer #(
    .LANES  (LANES),
    .BYTE_W (BYTE_W)
  ) u_byte_packer (
    .clk_i   (i_clk),
    .reset_i (i_reset),
    .en_i    (en),
    .valid_i (s2_valid_q),
    .byte_i  (s2_byte_q),
    .last_i  (s2_last_q),
    .ready_i (aq.i_ready),
    .valid_o (aq.o_valid),
    .data_o  (aq.o_data),
    .keep_o  (aq.o_keep),
    .last_o  (aq.o_last)
  );

endmodule

// File: tb/tb_act_quantizer.sv
// tb_act_quantizer: directed self-checking bench for act_quantizer.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. A falling-edge monitor records every transferred word.
module tb_act_quantizer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  act_quantizer_if #(.IN_W(32), .SCALE_W(32), .LANES(4)) aq ();

  act_quantizer #(
    .IN_W       (32),
    .SCALE_W    (32),
    .FRAC_SHIFT (32),
    .LANES      (4)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .aq      (aq)
  );

  localparam logic [31:0] ONE = 32'h0001_0000;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mon_data[$];
  logic [3:0]  mon_keep[$];
  logic        mon_last[$];

  always @(negedge clk) begin
    if (!reset && aq.o_valid && aq.i_ready) begin
      mon_data.push_back(aq.o_data);
      mon_keep.push_back(aq.o_keep);
      mon_last.push_back(aq.o_last);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_data.delete();
    mon_keep.delete();
    mon_last.delete();
  endtask

  // Present one element and hold it until o_ready was high at an edge.
  task automatic send(input logic [31:0] d, input logic [31:0] s, input logic l);
    bit acc = 1'b0;
    aq.i_valid = 1'b1;
    aq.i_data  = d;
    aq.i_inv_s = s;
    aq.i_last  = l;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      acc = aq.o_ready;
      tick();
    end
    aq.i_valid = 1'b0;
    aq.i_last  = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: element %h not accepted within 100 cycles, required accept", d);
    end
  endtask

  // Wait (bounded) for n words, then a few idle cycles to expose duplicates.
  task automatic wait_words(input int n);
    for (int k = 0; k < 200 && mon_data.size() < n; k++) tick();
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    aq.i_valid = 1'b0;
    aq.i_data  = '0;
    aq.i_inv_s = '0;
    aq.i_last  = 1'b0;
    aq.i_ready = 1'b0;
    tick();
    tick();
    n_checks++;
    if (aq.o_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_o_valid: got %b, required 0", aq.o_valid);
    end
    n_checks++;
    if (aq.o_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_o_data: got %h, required 00000000", aq.o_data);
    end
    n_checks++;
    if (aq.o_keep !== 4'b0000 || aq.o_last !== 1'b0) begin
      n_fail++; $display("FAIL reset_keep_last: got %b/%b, required 0000/0", aq.o_keep, aq.o_last);
    end
    n_checks++;
    if (aq.o_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_o_ready: got %b, required 1", aq.o_ready);
    end
`ifdef QUANT_STATS_EN
    n_checks++;
    if (aq.o_sat_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_sat_count: got %0d, required 0", aq.o_sat_count);
    end
`endif
    reset = 1'b0;
    tick();
  endtask

  // Single-element tiles exercising round half-up and zero scale.
  task automatic test_round();
    logic [31:0] din[5]  = '{32'h0005_8000, 32'h0003_0000, 32'h0000_7FFF, 32'h0000_8000,
                             32'h1234_5678};
    logic [31:0] sin[5]  = '{ONE, 32'h0002_0000, ONE, ONE, 32'h0};
    logic [31:0] dexp[5] = '{32'h06, 32'h06, 32'h00, 32'h01, 32'h00};
    logic [31:0] got;
    aq.i_ready = 1'b1;
    clear_mon();
    for (int i = 0; i < 5; i++) send(din[i], sin[i], 1'b1);
    wait_words(5);
    n_checks++;
    if (mon_data.size() != 5) begin
      n_fail++; $display("FAIL round_count: got %0d words, required 5", mon_data.size());
    end
    for (int i = 0; i < 5; i++) begin
      got = (i < mon_data.size()) ? mon_data[i] : 32'hxxxx_xxxx;
      n_checks++;
      if (got !== dexp[i] || (i < mon_data.size() &&
          (mon_keep[i] !== 4'b0001 || mon_last[i] !== 1'b1))) begin
        n_fail++;
        $display("FAIL round_%0d: got data %h, required %h keep 0001 last 1", i, got, dexp[i]);
      end
    end
  endtask

  // Four elements form one word; check the three-cycle latency.
  task automatic test_word();
    clear_mon();
    for (int k = 1; k <= 4; k++) send(32'(k) << 16, ONE, 1'b0);
    n_checks++;
    if (aq.o_valid !== 1'b0) begin
      n_fail++; $display("FAIL word_early_t1: got o_valid %b, required 0", aq.o_valid);
    end
    tick();
    n_checks++;
    if (aq.o_valid !== 1'b0) begin
      n_fail++; $display("FAIL word_early_t2: got o_valid %b, required 0", aq.o_valid);
    end
    tick();
    n_checks++;
    if (aq.o_valid !== 1'b1 || aq.o_data !== 32'h0403_0201 || aq.o_keep !== 4'b1111 ||
        aq.o_last !== 1'b0) begin
      n_fail++;
      $display("FAIL word_t3: got v %b data %h keep %b last %b, required 1 04030201 1111 0",
               aq.o_valid, aq.o_data, aq.o_keep, aq.o_last);
    end
    wait_words(1);
    n_checks++;
    if (mon_data.size() != 1) begin
      n_fail++; $display("FAIL word_count: got %0d words, required 1", mon_data.size());
    end
  endtask

  // Partial word flushed by i_last, then the next tile restarts at lane 0.
  task automatic test_partial_last();
    clear_mon();
    send(32'h0007_0000, ONE, 1'b0);
    send(32'h0009_0000, ONE, 1'b1);
    send(32'h0005_0000, ONE, 1'b1);
    wait_words(2);
    n_checks++;
    if (mon_data.size() != 2) begin
      n_fail++; $display("FAIL partial_count: got %0d words, required 2", mon_data.size());
    end else begin
      n_checks++;
      if (mon_data[0] !== 32'h0000_0907 || mon_keep[0] !== 4'b0011 || mon_last[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL partial_word0: got %h %b %b, required 00000907 0011 1",
                 mon_data[0], mon_keep[0], mon_last[0]);
      end
      n_checks++;
      if (mon_data[1] !== 32'h0000_0005 || mon_keep[1] !== 4'b0001 || mon_last[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL partial_word1: got %h %b %b, required 00000005 0001 1",
                 mon_data[1], mon_keep[1], mon_last[1]);
      end
    end
  endtask

  // i_last on the final lane gives a full word with o_last set.
  task automatic test_full_last();
    clear_mon();
    for (int k = 1; k <= 4; k++) send(32'(k) << 16, ONE, k == 4);
    wait_words(1);
    n_checks++;
    if (mon_data.size() != 1 || mon_data[0] !== 32'h0403_0201 || mon_keep[0] !== 4'b1111 ||
        mon_last[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL full_last: got %0d words, first %h, required 04030201 1111 last 1",
               mon_data.size(), (mon_data.size() > 0) ? mon_data[0] : 32'hx);
    end
  endtask

  task automatic test_saturate();
    clear_mon();
    send(32'h0200_0000, ONE, 1'b1);
    wait_words(1);
    n_checks++;
    if (mon_data.size() != 1 || mon_data[0] !== 32'h0000_00FF || mon_keep[0] !== 4'b0001) begin
      n_fail++;
      $display("FAIL sat_single: got %0d words, first %h, required 000000FF keep 0001",
               mon_data.size(), (mon_data.size() > 0) ? mon_data[0] : 32'hx);
    end
`ifdef QUANT_STATS_EN
    n_checks++;
    if (aq.o_sat_count !== 16'd1) begin
      n_fail++; $display("FAIL sat_count_1: got %0d, required 1", aq.o_sat_count);
    end
`endif
    // 512.0 and 511.5 saturate; 255.4 rounds to 255 without saturating.
    clear_mon();
    send(32'h0200_0000, ONE, 1'b0);
    send(32'h01FF_8000, ONE, 1'b0);
    send(32'h00FF_6666, ONE, 1'b1);
    wait_words(1);
    n_checks++;
    if (mon_data.size() != 1 || mon_data[0] !== 32'h00FF_FFFF || mon_keep[0] !== 4'b0111) begin
      n_fail++;
      $display("FAIL sat_tile: got %0d words, first %h, required 00FFFFFF keep 0111",
               mon_data.size(), (mon_data.size() > 0) ? mon_data[0] : 32'hx);
    end
`ifdef QUANT_STATS_EN
    n_checks++;
    if (aq.o_sat_count !== 16'd2) begin
      n_fail++; $display("FAIL sat_count_2: got %0d, required 2", aq.o_sat_count);
    end
`endif
  endtask

  // Twelve elements with i_ready low for five cycles mid-stream.
  task automatic test_back_to_back_stall();
    logic [31:0] held_val = '0;
    int          held     = 0;
    logic [31:0] wexp[3]  = '{32'h0403_0201, 32'h0807_0605, 32'h0C0B_0A09};
    clear_mon();
    aq.i_ready = 1'b1;
    fork
      begin
        for (int k = 1; k <= 12; k++) send(32'(k) << 16, ONE, 1'b0);
      end
      begin
        repeat (4) tick();
        aq.i_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          if (aq.o_valid) begin
            held++;
            n_checks++;
            if (aq.o_ready !== 1'b0) begin
              n_fail++; $display("FAIL stall_o_ready: got %b, required 0", aq.o_ready);
            end
            if (held == 1) begin
              held_val = aq.o_data;
            end else begin
              n_checks++;
              if (aq.o_data !== held_val) begin
                n_fail++; $display("FAIL stall_hold: got %h, required %h", aq.o_data, held_val);
              end
            end
          end
        end
        tick();
        aq.i_ready = 1'b1;
      end
    join
    n_checks++;
    if (held == 0) begin
      n_fail++; $display("FAIL stall_held_cycles: got 0 held cycles, required at least 1");
    end
    wait_words(3);
    n_checks++;
    if (mon_data.size() != 3) begin
      n_fail++; $display("FAIL stall_count: got %0d words, required 3", mon_data.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= mon_data.size() || mon_data[i] !== wexp[i] || mon_keep[i] !== 4'b1111) begin
        n_fail++;
        $display("FAIL stall_word_%0d: got %h, required %h keep 1111", i,
                 (i < mon_data.size()) ? mon_data[i] : 32'hx, wexp[i]);
      end
    end
  endtask

  // Reset after two of four elements; the next four must form a clean word.
  task automatic test_reset_mid_tile();
    clear_mon();
    send(32'h0001_0000, ONE, 1'b0);
    send(32'h0002_0000, ONE, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if (aq.o_valid !== 1'b0 || aq.o_data !== 32'h0 || aq.o_keep !== 4'b0000 ||
        aq.o_last !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got v %b data %h keep %b last %b, required all 0",
               aq.o_valid, aq.o_data, aq.o_keep, aq.o_last);
    end
    reset = 1'b0;
    clear_mon();
    for (int k = 0; k < 4; k++) send(32'(8'h11 + k) << 16, ONE, 1'b0);
    wait_words(1);
    n_checks++;
    if (mon_data.size() != 1 || mon_data[0] !== 32'h1413_1211 || mon_keep[0] !== 4'b1111) begin
      n_fail++;
      $display("FAIL midreset_word: got %0d words, first %h, required 14131211 keep 1111",
               mon_data.size(), (mon_data.size() > 0) ? mon_data[0] : 32'hx);
    end
  endtask

  initial begin
    test_reset();
    test_round();
    test_word();
    test_partial_last();
    test_full_last();
    test_saturate();
    test_back_to_back_stall();
    test_reset_mid_tile();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
